// File: rtl/fwd_result_pipe.sv
// Result/forwarding shift pipeline: per-stage injection, partial flush, collision flag, lookup.
// Define FWD_PERF_CNT_EN to add the wb_count / coll_count performance counters.
module fwd_result_pipe #(
   parameter int unsigned      DEPTH        = 7,
   parameter int unsigned      PKT_W        = 139,
   parameter logic [DEPTH-1:0] INJ_MASK     = 7'b1100101,
   parameter int unsigned      FLUSH_STAGES = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [DEPTH:1][PKT_W-1:0] inj_pkt,
   output logic [DEPTH:1][PKT_W-1:0] fw_out,
   output logic [PKT_W-1:0]          wb_out,
   input  logic [6:0]                lk_addr,
   output logic                      lk_hit,
   output logic [127:0]              lk_data,
   output logic                      collision
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]               wb_count,
   output logic [15:0]               coll_count
`endif
);

   localparam int unsigned VldBit = 131;
   localparam int unsigned RtLsb  = 132;

   logic [DEPTH:2][PKT_W-1:0] r_q, r_d;
   logic [DEPTH:1]            live;
   logic [PKT_W-1:0]          wb_q;
   logic                      coll_q;
   logic                      coll_evt;

   // Stage view: a live injection overrides the stage register.
   always_comb begin
      live      = '0;
      fw_out    = '0;
      coll_evt  = 1'b0;
      live[1]   = INJ_MASK[0] && inj_pkt[1][VldBit];
      fw_out[1] = live[1] ? inj_pkt[1] : '0;
      for (int s = 2; s <= DEPTH; s++) begin
         live[s]   = INJ_MASK[s-1] && inj_pkt[s][VldBit];
         fw_out[s] = live[s] ? inj_pkt[s] : r_q[s];
         if (live[s] && r_q[s][VldBit]) coll_evt = 1'b1;
      end
   end

   // Shift with valid squashed for packets leaving the flushable stages.
   always_comb begin
      r_d = '0;
      for (int s = 2; s <= DEPTH; s++) begin
         r_d[s] = fw_out[s-1];
         if (flush && ((s - 1) <= FLUSH_STAGES)) r_d[s][VldBit] = 1'b0;
      end
   end

   // Oldest candidate first so that younger matches overwrite it.
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      if (wb_q[VldBit] && (wb_q[RtLsb +: 7] == lk_addr)) begin
         lk_hit  = 1'b1;
         lk_data = wb_q[127:0];
      end
      for (int s = DEPTH; s >= 1; s--) begin
         if (fw_out[s][VldBit] && (fw_out[s][RtLsb +: 7] == lk_addr)) begin
            lk_hit  = 1'b1;
            lk_data = fw_out[s][127:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q    <= '0;
         wb_q   <= '0;
         coll_q <= 1'b0;
      end else begin
         r_q  <= r_d;
         wb_q <= fw_out[DEPTH];
         if (coll_evt) coll_q <= 1'b1;
      end
   end

   assign wb_out    = wb_q;
   assign collision = coll_q;

`ifdef FWD_PERF_CNT_EN
   logic [31:0] wb_cnt_q;
   logic [15:0] coll_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_cnt_q   <= '0;
         coll_cnt_q <= '0;
      end else begin
         if (fw_out[DEPTH][VldBit]) wb_cnt_q <= wb_cnt_q + 32'd1;
         if (coll_evt && (coll_cnt_q != 16'hFFFF)) coll_cnt_q <= coll_cnt_q + 16'd1;
      end
   end

   assign wb_count   = wb_cnt_q;
   assign coll_count = coll_cnt_q;
`endif

endmodule
